// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared widths, address field positions and access kinds for mem_manager.
// Revision : 1.0
// ============================================================================
package mm_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int ADDRESS_WIDTH = 23;
    localparam int CORE_WIDTH    = 16;
    localparam int NUM_REGS      = 8;
    localparam int NUM_CORES     = 64;

    // Host byte-address field positions
    localparam int LANE_BIT    = 0;
    localparam int WORD_LSB    = 1;
    localparam int WORD_MSB    = 16;
    localparam int CORE_LSB    = 17;
    localparam int CORE_MSB    = 22;
    localparam int REG_SEL_LSB = 1;
    localparam int REG_SEL_MSB = 3;

    localparam int CORE_IDX_W = CORE_MSB - CORE_LSB + 1;
    localparam int REG_IDX_W  = REG_SEL_MSB - REG_SEL_LSB + 1;

    localparam logic [CORE_WIDTH-1:0] REG_WINDOW_BASE = 16'hFFF8;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_READ  = 2'd2
    } acc_t;

    function automatic logic is_reg_word(input logic [CORE_WIDTH-1:0] word);
        return word >= REG_WINDOW_BASE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder
// Purpose  : N-to-2^N one-hot decoder; all-zero output when disabled.
// Revision : 1.0
// ============================================================================
module onehot_decoder #(
    parameter int N = 3
) (
    input  logic              i_en,
    input  logic [N-1:0]      i_sel,
    output logic [2**N-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_manager.sv
`default_nettype none
// ============================================================================
// Module   : mem_manager
// Purpose  : 8-bit host to 64x16-bit core array bridge with registered decode.
// Revision : 1.0
// ============================================================================
module mem_manager
    import mm_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    inout  wire  [DATA_WIDTH-1:0]    data,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     wren_in,
    inout  wire  [CORE_WIDTH-1:0]    core_data,
    output logic [CORE_WIDTH-1:0]    core_address,
    output logic                     wren_out,
    output logic [NUM_REGS-1:0]      reg_en,
    output logic [NUM_CORES-1:0]     core_en
);

    logic                  w_lane;
    logic [CORE_WIDTH-1:0] w_word;
    logic [CORE_IDX_W-1:0] w_core_idx;
    logic [REG_IDX_W-1:0]  w_reg_idx;
    acc_t                  w_acc;
    logic                  w_access;
    logic [NUM_CORES-1:0]  w_core_onehot;
    logic [NUM_REGS-1:0]   w_reg_onehot;
    logic [DATA_WIDTH-1:0] w_rd_byte;

    acc_t                  r_acc;
    logic                  r_lane;
    logic [DATA_WIDTH-1:0] r_low_latch;
    logic [CORE_WIDTH-1:0] r_wdata;
    logic [CORE_WIDTH-1:0] r_core_addr;
    logic [NUM_CORES-1:0]  r_core_en;
    logic [NUM_REGS-1:0]   r_reg_en;

    assign w_lane     = address[LANE_BIT];
    assign w_word     = address[WORD_MSB:WORD_LSB];
    assign w_core_idx = address[CORE_MSB:CORE_LSB];
    assign w_reg_idx  = address[REG_SEL_MSB:REG_SEL_LSB];

    // An even-byte write only fills the latch; everything else touches a core.
    always_comb begin
        w_acc = ACC_NONE;
        if (!wren_in) begin
            w_acc = ACC_READ;
        end else if (w_lane) begin
            w_acc = ACC_WRITE;
        end
    end

    assign w_access = (w_acc != ACC_NONE);

    onehot_decoder #(
        .N (CORE_IDX_W)
    ) u_core_dec (
        .i_en     (w_access),
        .i_sel    (w_core_idx),
        .o_onehot (w_core_onehot)
    );

    onehot_decoder #(
        .N (REG_IDX_W)
    ) u_reg_dec (
        .i_en     (w_access && is_reg_word(w_word)),
        .i_sel    (w_reg_idx),
        .o_onehot (w_reg_onehot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= ACC_NONE;
            r_lane      <= 1'b0;
            r_low_latch <= '0;
            r_wdata     <= '0;
            r_core_addr <= '0;
            r_core_en   <= '0;
            r_reg_en    <= '0;
        end else begin
            r_acc     <= w_acc;
            r_lane    <= w_lane;
            r_core_en <= w_core_onehot;
            r_reg_en  <= w_reg_onehot;
            if (w_access) begin
                r_core_addr <= w_word;
            end
            if (w_acc == ACC_NONE) begin
                r_low_latch <= data;
            end
            if (w_acc == ACC_WRITE) begin
                r_wdata <= {data, r_low_latch};
            end
        end
    end

    assign core_address = r_core_addr;
    assign wren_out     = (r_acc == ACC_WRITE);
    assign reg_en       = r_reg_en;
    assign core_en      = r_core_en;

    assign core_data = (r_acc == ACC_WRITE) ? r_wdata : {CORE_WIDTH{1'bz}};

    // The host may already be driving the next write while a read cycle is active.
    assign w_rd_byte = r_lane ? core_data[15:8] : core_data[7:0];
    assign data      = ((r_acc == ACC_READ) && !wren_in) ? w_rd_byte : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_manager
// Purpose  : Randomised and directed checks of mem_manager against a request-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_manager;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        wren_in   = 1'b0;
    logic [22:0] address   = '0;
    logic [7:0]  host_data = '0;
    logic        beef_mode = 1'b0;

    wire  [7:0]  data;
    wire  [15:0] core_data;
    logic [15:0] core_address;
    logic        wren_out;
    logic [7:0]  reg_en;
    logic [63:0] core_en;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_manager dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .address      (address),
        .wren_in      (wren_in),
        .core_data    (core_data),
        .core_address (core_address),
        .wren_out     (wren_out),
        .reg_en       (reg_en),
        .core_en      (core_en)
    );

    // Undriven buses float high, so a released bus reads as all ones.
    pullup (data);
    pullup (core_data);

    assign data = wren_in ? host_data : 8'hzz;

    function automatic logic [5:0] oh_index(input logic [63:0] v);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) return 6'(i);
        end
        return 6'd0;
    endfunction

    function automatic logic [15:0] core_resp(input logic [5:0] idx, input logic [15:0] word,
                                              input logic beef);
        if (beef) return 16'hBEEF;
        return {word[7:0] ^ {2'b00, idx}, word[15:8] ^ 8'hA5};
    endfunction

    // Core array: drives its data port whenever it is selected for a read.
    assign core_data = ((core_en != 64'd0) && !wren_out)
                       ? core_resp(oh_index(core_en), core_address, beef_mode) : 16'hzzzz;

    function automatic logic [15:0] word_of(input logic [22:0] a);
        return 16'((a >> 1) % 65536);
    endfunction

    function automatic logic [5:0] core_of(input logic [22:0] a);
        return 6'(a / 131072);
    endfunction

    function automatic logic lane_of(input logic [22:0] a);
        return (a % 2) == 1;
    endfunction

    // Request-level model: what the strobes must look like during the cycle after a request.
    logic        m_valid, m_wr;
    logic [5:0]  m_idx;
    logic [15:0] m_addr, m_wdata;
    logic [7:0]  m_reg, m_latch, m_rbyte;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_wr    <= 1'b0;
            m_idx   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_reg   <= '0;
            m_latch <= '0;
            m_rbyte <= '0;
        end else begin
            m_valid <= !(wren_in && !lane_of(address));
            m_wr    <= wren_in;
            m_idx   <= core_of(address);
            m_reg   <= (!(wren_in && !lane_of(address)) && word_of(address) >= 16'hFFF8)
                       ? (8'd1 << (word_of(address) - 16'hFFF8)) : 8'd0;
            if (!(wren_in && !lane_of(address))) m_addr <= word_of(address);
            if (wren_in && !lane_of(address)) m_latch <= host_data;
            if (wren_in && lane_of(address))  m_wdata <= {host_data, m_latch};
            m_rbyte <= lane_of(address)
                       ? core_resp(core_of(address), word_of(address), beef_mode) >> 8
                       : core_resp(core_of(address), word_of(address), beef_mode) % 256;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("core_en", core_en, m_valid ? (64'd1 << m_idx) : 64'd0);
            chk("reg_en", reg_en, m_valid ? m_reg : 8'd0);
            chk("wren_out", wren_out, m_valid && m_wr);
            chk("core_address", core_address, m_addr);
            if (m_valid && m_wr)  chk("core_data_wr", core_data, m_wdata);
            else if (!m_valid)    chk("core_data_z", core_data, 16'hFFFF);
            if (!wren_in) begin
                if (m_valid && !m_wr) chk("data_rd", data, m_rbyte);
                else                  chk("data_z", data, 8'hFF);
            end
        end
    end

    // Entered at negedge+1; drives at negedge+2; returns at the next negedge+1.
    task automatic step(input logic w, input logic [22:0] a, input logic [7:0] d);
        #1;
        wren_in   = w;
        address   = a;
        host_data = d;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_core_en"}, core_en, 64'd0);
        chk({tag, "_reg_en"}, reg_en, 8'd0);
        chk({tag, "_wren_out"}, wren_out, 1'b0);
        chk({tag, "_core_address"}, core_address, 16'd0);
        chk({tag, "_core_data_z"}, core_data, 16'hFFFF);
        chk({tag, "_data_z"}, data, 8'hFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rw;
        reset   = 1'b1;
        wren_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;

        // Reset in the middle of an active write, latch holding 0x99
        step(1'b1, 23'h000002, 8'h99);
        step(1'b1, 23'h000003, 8'h11);
        chk("pre_reset_core_data", core_data, 16'h1199);
        reset   = 1'b1;
        wren_in = 1'b0;
        #1;
        chk_idle("midreset");
        @(negedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 23'h000001, 8'hAB);
        chk("after_reset_core_data", core_data, 16'hAB00);
        chk("after_reset_core_en", core_en, 64'd1);

        step(1'b1, 23'h000000, 8'h05);
        chk("even_core_en", core_en, 64'd0);
        chk("even_wren_out", wren_out, 1'b0);
        step(1'b1, 23'h000001, 8'h00);
        chk("w0_core_en", core_en, 64'd1);
        chk("w0_core_address", core_address, 16'h0000);
        chk("w0_wren_out", wren_out, 1'b1);
        chk("w0_core_data", core_data, 16'h0005);
        chk("w0_reg_en", reg_en, 8'd0);

        step(1'b1, 23'h7E0002, 8'h34);
        step(1'b1, 23'h7E0003, 8'h12);
        chk("w63_core_en", core_en, 64'd1 << 63);
        chk("w63_core_address", core_address, 16'h0001);
        chk("w63_core_data", core_data, 16'h1234);

        step(1'b1, 23'h05FFF6, 8'h5A);
        step(1'b1, 23'h05FFF7, 8'hC3);
        chk("reg_reg_en", reg_en, 8'b0000_1000);
        chk("reg_core_en", core_en, 64'd1 << 2);
        chk("reg_wren_out", wren_out, 1'b1);
        chk("reg_core_address", core_address, 16'hFFFB);

        beef_mode = 1'b1;
        step(1'b0, 23'h020001, 8'h00);
        chk("rd_hi_core_en", core_en, 64'd1 << 1);
        chk("rd_hi_wren_out", wren_out, 1'b0);
        chk("rd_hi_data", data, 8'hBE);
        step(1'b0, 23'h020000, 8'h00);
        chk("rd_lo_data", data, 8'hEF);
        beef_mode = 1'b0;

        // Even-byte writes held for several cycles never reach a core
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 23'h000010, 8'h77);
            chk("hold_core_en", core_en, 64'd0);
            chk("hold_wren_out", wren_out, 1'b0);
        end
        step(1'b1, 23'h000011, 8'h66);
        chk("latched_core_data", core_data, 16'h6677);

        for (int i = 0; i < 400; i++) begin
            rw = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                             : 16'($urandom);
            step(1'($urandom_range(0, 1)),
                 {6'($urandom_range(0, 63)), rw, 1'($urandom_range(0, 1))},
                 8'($urandom));
        end

        step(1'b0, 23'h000000, 8'h00);
        step(1'b0, 23'h000000, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
